// File: rtl/cla_pkg.sv
// Shared constants and types for the 16-bit saturating CLA adder/subtractor.
// Width and group size are fixed; the lookahead equations in the top assume four groups.
package cla_pkg;

  localparam int DATA_W  = 16;
  localparam int GRP_W   = 4;
  localparam int NUM_GRP = DATA_W / GRP_W;

  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

  typedef logic [DATA_W-1:0] word_t;

  // Everything the output register captures each cycle.
  typedef struct packed {
    word_t sum;
    logic  cout;
    logic  ovfl;
  } res_t;

  // The clamp direction follows the sign of A: on overflow, both operand
  // signs agree, so A's sign is also the sign of the true result.
  function automatic word_t saturate(input word_t raw, input logic ovf, input logic a_msb);
    if (!ovf)
      return raw;
    else if (a_msb)
      return SAT_MIN;
    else
      return SAT_MAX;
  endfunction

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead group: internal carries come from flat lookahead terms
// rather than a ripple, and the group generate/propagate feed the second level.
module cla_4bit
  import cla_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             cin,
  output logic [GRP_W-1:0] s,
  output logic             gg,
  output logic             gp
);

  logic [GRP_W-1:0] g;
  logic [GRP_W-1:0] p;
  logic [GRP_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;

endmodule

// File: rtl/cla_16bit.sv
// 16-bit signed saturating add/sub: four CLA groups, a second-level lookahead
// across the groups, overflow clamp, and a single output register stage.
module cla_16bit
  import cla_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum,
  output logic        cout,
  output logic        ovfl
);

  word_t              b_eff;
  word_t              raw;
  logic [NUM_GRP-1:0] gg;
  logic [NUM_GRP-1:0] gp;
  logic [NUM_GRP:0]   gc;
  logic               ovf;
  res_t               nxt;
  res_t               q;

  // Subtraction is A + ~B + 1: invert B and inject the +1 as the carry-in.
  assign b_eff = b ^ {DATA_W{sub}};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GRP; gi++) begin : g_grp
      cla_4bit u_grp (
        .a   (a[gi*GRP_W +: GRP_W]),
        .b   (b_eff[gi*GRP_W +: GRP_W]),
        .cin (gc[gi]),
        .s   (raw[gi*GRP_W +: GRP_W]),
        .gg  (gg[gi]),
        .gp  (gp[gi])
      );
    end
  endgenerate

  // Group carries are each a flat sum of products of G/P and c0, so no
  // carry ever passes through more than one group's internal logic.
  assign gc[0] = sub;
  assign gc[1] = gg[0] | (gp[0] & gc[0]);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & gc[0]);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & gc[0]);

  assign ovf = (a[DATA_W-1] == b_eff[DATA_W-1]) && (raw[DATA_W-1] != a[DATA_W-1]);

  always_comb begin
    nxt      = '0;
    nxt.sum  = saturate(raw, ovf, a[DATA_W-1]);
    nxt.cout = gc[NUM_GRP];
    nxt.ovfl = ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else
      q <= nxt;
  end

  assign sum  = q.sum;
  assign cout = q.cout;
  assign ovfl = q.ovfl;

endmodule

// File: tb/tb_cla_16bit.sv
// Directed and random checks of cla_16bit against an integer-arithmetic model
// of signed saturating add/sub with unsigned carry/no-borrow semantics.
module tb_cla_16bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic [15:0] sum;
  logic        cout;
  logic        ovfl;

  int total = 0;
  int bad   = 0;

  cla_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .sub   (sub),
    .sum   (sum),
    .cout  (cout),
    .ovfl  (ovfl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic s,
                                output logic [15:0] r, output logic c, output logic o);
    int          sx;
    int          sy;
    int          res;
    int unsigned ux;
    int unsigned uy;
    sx  = int'($signed(x));
    sy  = int'($signed(y));
    ux  = {16'h0, x};
    uy  = {16'h0, y};
    res = s ? (sx - sy) : (sx + sy);
    o   = (res > 32767) || (res < -32768);
    if (!o)          r = res[15:0];
    else if (res > 0) r = 16'h7FFF;
    else             r = 16'h8000;
    c = s ? (ux >= uy) : ((ux + uy) > 32'd65535);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] es, input logic ec, input logic eo);
    chk({tag, ".sum"},  sum,            es);
    chk({tag, ".cout"}, {15'h0, cout},  {15'h0, ec});
    chk({tag, ".ovfl"}, {15'h0, ovfl},  {15'h0, eo});
  endtask

  // Apply one operation at the falling edge and check it just after the next rising edge.
  task automatic step(input string tag, input logic [15:0] x, input logic [15:0] y, input logic s,
                      input logic [15:0] es, input logic ec, input logic eo);
    logic [15:0] ms;
    logic        mc;
    logic        mo;
    @(negedge clk);
    a = x; b = y; sub = s;
    @(posedge clk);
    #1;
    chk_out(tag, es, ec, eo);
    model(x, y, s, ms, mc, mo);
    chk({tag, ".model"}, {ms[14:0], mc}, {es[14:0], ec});
  endtask

  initial begin
    logic [15:0] rx;
    logic [15:0] ry;
    logic        rs;
    logic [15:0] es;
    logic        ec;
    logic        eo;

    rst_n = 1'b0;
    a = 16'h1234; b = 16'h1111; sub = 1'b0;
    #2;
    chk_out("reset_init", 16'h0000, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    step("rst_release", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle, well away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("reset_async", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_out("reset_resume", 16'h2345, 1'b0, 1'b0);

    step("c_00ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    step("c_ffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    step("c_0fff", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
    step("sat_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    step("sat_neg", 16'h8000, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    step("sub_5_3", 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
    step("sub_3_5", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    step("ssat_min", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1);
    step("ssat_max", 16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b0, 1'b1);
    step("ssat_0m", 16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b0, 1'b1);
    step("sub_mm", 16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Inputs moving between edges must not disturb the registered result.
    #2;
    a = 16'h7FFF; b = 16'h7FFF; sub = 1'b0;
    #3;
    chk_out("hold", 16'h0000, 1'b1, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rs = 1'($urandom);
      if ($urandom_range(0, 7) == 0) rx = {rx[0], 15'h0} ^ {16{rx[1]}};
      if ($urandom_range(0, 7) == 0) ry = {ry[0], 15'h0} ^ {16{ry[1]}};
      model(rx, ry, rs, es, ec, eo);
      @(negedge clk);
      a = rx; b = ry; sub = rs;
      @(posedge clk);
      #1;
      chk_out("rand", es, ec, eo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_16bit.md
Name: cla_16bit

Overview:
16-bit signed saturating adder/subtractor built on a two-level carry-lookahead (CLA) network. It sits in the ALU datapath, serving ADD/SUB-class operations. Operands are two's-complement. Outputs are registered: one clock of latency.

Parameters:
None. Width is fixed at 16 bits. The 4-bit group size is fixed.

Ports:
clk    input   1   rising-edge clock
rst_n  input   1   asynchronous active-low reset
a      input   16  operand A, signed two's-complement
b      input   16  operand B, signed two's-complement
sub    input   1   0 = A+B, 1 = A-B
sum    output  16  saturated signed result (registered)
cout   output  1   raw carry-out of bit 15 of the unsaturated add (registered)
ovfl   output  1   signed overflow occurred; saturation applied (registered)

Behaviour:
- Reset and clocking:
  - One clock domain (clk).
  - Reset is asynchronous and active-low (rst_n).
  - While rst_n=0: sum=16'h0000, cout=0, ovfl=0.
  - Reset takes effect immediately, regardless of clk.
  - Outputs update on the first rising edge after rst_n deasserts.
- Operand conditioning:
  - b_eff = b XOR {16{sub}}.
  - Carry-in c0 = sub. A-B is therefore computed as A + ~B + 1.
- Raw sum: raw[15:0], carry c16 = a + b_eff + c0.
- CLA structure:
  - Per bit: g_i = a_i & b_eff_i, p_i = a_i ^ b_eff_i.
  - Four 4-bit groups. Each group produces group G/P and internal carries by lookahead, not by ripple.
  - A second-level lookahead unit computes c4, c8, c12 and c16 from the group G/P values and c0.
  - Sum bit: s_i = p_i ^ c_i.
  - No ripple path longer than one group is permitted.
- Overflow: ovf = (a[15] == b_eff[15]) && (raw[15] != a[15]).
- Saturation:
  - ovf && a[15]==0 → result 16'h7FFF (positive clamp).
  - ovf && a[15]==1 → result 16'h8000 (negative clamp).
  - Otherwise result = raw.
- Register stage:
  - On each rising clk: sum <= result, cout <= c16, ovfl <= ovf.
  - Latency 1 cycle; throughput 1 operation per cycle; no handshake, no stall.
- cout semantics:
  - Reflects the unsaturated carry-out, including during saturation.
  - For sub, cout=1 means no borrow (unsigned A >= B).
- Boundary conditions:
  - 0x8000 - 0x8000 = 0x0000: no overflow, cout=1.
  - 0 - 0x8000 overflows positive → 0x7FFF.
  - Input changes between edges do not affect registered outputs.

Decomposition:
- Shared package cla_pkg:
  - constants DATA_W=16, GRP_W=4, SAT_MAX=16'h7FFF, SAT_MIN=16'h8000;
  - typedef word_t (logic [15:0]).
- Sub-module cla_4bit:
  - inputs a[3:0], b[3:0], cin;
  - outputs s[3:0], gg, gp.
- Top level contents:
  - four cla_4bit instances;
  - the second-level carry lookahead;
  - the overflow/saturation mux;
  - the output register.

Test Plan:
1. Reset: rst_n=0 asynchronously mid-cycle with a=0x1234, b=0x1111 → sum=0x0000, cout=0, ovfl=0 immediately. Release reset, next edge → sum=0x2345.
2. Carry chain: add 0x00FF+0x0001 → 0x0100, cout=0. Add 0xFFFF+0x0001 → 0x0000, cout=1, ovfl=0. Add 0x0FFF+0x0001 → 0x1000.
3. Add saturation: 0x7FFF+0x0001 → sum=0x7FFF, ovfl=1, cout=0. 0x8000+0xFFFF → sum=0x8000, ovfl=1, cout=1.
4. Subtraction: 0x0005-0x0003 → 0x0002, cout=1. 0x0003-0x0005 → 0xFFFE, cout=0, ovfl=0.
5. Sub saturation: 0x8000-0x0001 → 0x8000, ovfl=1. 0x7FFF-0xFFFF → 0x7FFF, ovfl=1. 0x0000-0x8000 → 0x7FFF, ovfl=1. 0x8000-0x8000 → 0x0000, ovfl=0.
6. Random regression: 10k cycles of random a, b, sub, with a reference model of the saturating add/sub. Compare sum/cout/ovfl one cycle after the operands are applied. Zero mismatches required.
